// File: rtl/alu_pkg.sv
// Shared funct codes, ALU control codes, sequencer state constants and decode helpers.
package alu_pkg;

  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLL   = 6'b000000;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MULTU = 6'b011001;

  localparam logic [2:0] C_AND = 3'b000;
  localparam logic [2:0] C_OR  = 3'b001;
  localparam logic [2:0] C_ADD = 3'b010;
  localparam logic [2:0] C_SUB = 3'b110;
  localparam logic [2:0] C_SLT = 3'b111;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_MUL  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  function automatic logic [2:0] alu_ctrl_of(input logic [5:0] f);
    case (f)
      F_AND:   return C_AND;
      F_OR:    return C_OR;
      F_ADD:   return C_ADD;
      F_SUB:   return C_SUB;
      F_SLT:   return C_SLT;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic funct_known(input logic [5:0] f);
    case (f)
      F_AND, F_OR, F_ADD, F_SUB, F_SLT, F_SLL, F_MFHI, F_MFLO, F_MULTU: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mult32u_seq.sv
// 32-iteration unsigned shift-add multiplier; start loads operands, run advances one step.
// product_next is the value the register takes on the next run edge, so callers can capture the final product on the last step.
module mult32u_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        run,
  input  logic [31:0] mcand_in,
  input  logic [31:0] mplier_in,
  output logic        last,
  output logic [63:0] product_next
);

  logic [31:0] mcand;
  logic [63:0] product;
  logic [4:0]  count;
  logic [32:0] sum;
  logic [32:0] upper;

  // Upper half is summed 33 bits wide so the carry survives the right shift.
  always_comb begin
    sum          = {1'b0, product[63:32]} + {1'b0, mcand};
    upper        = product[0] ? sum : {1'b0, product[63:32]};
    product_next = {upper, product[31:1]};
  end

  assign last = run && (count == 5'd31);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand   <= '0;
      product <= '0;
      count   <= '0;
    end else if (start) begin
      mcand   <= mcand_in;
      product <= {32'b0, mplier_in};
      count   <= '0;
    end else if (run) begin
      product <= product_next;
      count   <= count + 5'd1;
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// ALU issue/sequencing front end: funct decode, registered result-select, Hi/Lo and MULTU control.
// Single-cycle ops complete one cycle after accept; MULTU holds op_ready low for 33 cycles.
module alu_op_sequencer
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [5:0]  funct,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic [5:0]  sel_funct,
  output logic [2:0]  alu_ctrl,
  output logic        done,
  output logic        illegal,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  state_t      state;
  logic        accept;
  logic        mul_start;
  logic        mul_run;
  logic        mul_last;
  logic [63:0] product_next;

  assign op_ready  = (state == ST_IDLE);
  assign accept    = op_valid && op_ready;
  assign mul_start = accept && (funct == F_MULTU);
  assign mul_run   = (state == ST_MUL);

  mult32u_seq u_mult (
    .clk          (clk),
    .reset        (reset),
    .start        (mul_start),
    .run          (mul_run),
    .mcand_in     (src_a),
    .mplier_in    (src_b),
    .last         (mul_last),
    .product_next (product_next)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      sel_funct <= '0;
      alu_ctrl  <= '0;
      done      <= 1'b0;
      illegal   <= 1'b0;
      hi_out    <= '0;
      lo_out    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            sel_funct <= funct;
            alu_ctrl  <= alu_ctrl_of(funct);
            if (funct == F_MULTU) begin
              state   <= ST_MUL;
              done    <= 1'b0;
              illegal <= 1'b0;
            end else begin
              done    <= 1'b1;
              illegal <= !funct_known(funct);
            end
          end else begin
            done    <= 1'b0;
            illegal <= 1'b0;
          end
        end
        ST_MUL: begin
          illegal <= 1'b0;
          done    <= 1'b0;
          // Hi/Lo take the final product on the same edge as the last step, so done lines up with DONE.
          if (mul_last) begin
            hi_out <= product_next[63:32];
            lo_out <= product_next[31:0];
            done   <= 1'b1;
            state  <= ST_DONE;
          end
        end
        ST_DONE: begin
          done    <= 1'b0;
          illegal <= 1'b0;
          state   <= ST_IDLE;
        end
        default: begin
          done    <= 1'b0;
          illegal <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomized bench for alu_op_sequencer with a cycle-level behavioural model and directed literal checks.
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid;
  logic        op_ready;
  logic [5:0]  funct;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [5:0]  sel_funct;
  logic [2:0]  alu_ctrl;
  logic        done;
  logic        illegal;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  int errors = 0;
  int checks = 0;
  logic cmp_en = 1'b0;

  alu_op_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .funct     (funct),
    .src_a     (src_a),
    .src_b     (src_b),
    .sel_funct (sel_funct),
    .alu_ctrl  (alu_ctrl),
    .done      (done),
    .illegal   (illegal),
    .hi_out    (hi_out),
    .lo_out    (lo_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] ref_ctrl(input logic [5:0] f);
    case (f)
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b101010: return 3'b111;
      default:   return 3'b000;
    endcase
  endfunction

  function automatic logic ref_known(input logic [5:0] f);
    case (f)
      6'b100100, 6'b100101, 6'b100000, 6'b100010, 6'b101010,
      6'b000000, 6'b010000, 6'b010010, 6'b011001: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Behavioural model: a MULTU is a 33-cycle busy window ending with the full 64-bit product.
  logic        m_ready;
  int          m_cnt;
  logic [5:0]  m_sel;
  logic [2:0]  m_ctrl;
  logic        m_done;
  logic        m_ill;
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  logic [63:0] m_pend;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_ready <= 1'b1;
      m_cnt   <= 0;
      m_sel   <= '0;
      m_ctrl  <= '0;
      m_done  <= 1'b0;
      m_ill   <= 1'b0;
      m_hi    <= '0;
      m_lo    <= '0;
      m_pend  <= '0;
    end else if (m_ready) begin
      if (op_valid) begin
        m_sel  <= funct;
        m_ctrl <= ref_ctrl(funct);
        if (funct == 6'b011001) begin
          m_ready <= 1'b0;
          m_cnt   <= 33;
          m_pend  <= 64'(src_a) * 64'(src_b);
          m_done  <= 1'b0;
          m_ill   <= 1'b0;
        end else begin
          m_done <= 1'b1;
          m_ill  <= !ref_known(funct);
        end
      end else begin
        m_done <= 1'b0;
        m_ill  <= 1'b0;
      end
    end else begin
      m_cnt  <= m_cnt - 1;
      m_done <= 1'b0;
      m_ill  <= 1'b0;
      if (m_cnt == 2) begin
        m_hi   <= m_pend[63:32];
        m_lo   <= m_pend[31:0];
        m_done <= 1'b1;
      end else if (m_cnt == 1) begin
        m_ready <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en && !reset) begin
      chk("op_ready", op_ready, m_ready);
      chk("sel_funct", sel_funct, m_sel);
      chk("alu_ctrl", alu_ctrl, m_ctrl);
      chk("done", done, m_done);
      chk("illegal", illegal, m_ill);
      chk("hi_out", hi_out, m_hi);
      chk("lo_out", lo_out, m_lo);
    end
  end

  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    op_valid = 1'b1;
    funct    = f;
    src_a    = a;
    src_b    = b;
    @(negedge clk);
    op_valid = 1'b0;
  endtask

  task automatic wait_mul(output int low, output int done_idx);
    low      = 0;
    done_idx = -1;
    while (!op_ready && low < 40) begin
      if (done) done_idx = low;
      low++;
      @(negedge clk);
    end
  endtask

  logic [5:0] codes [10];
  int low;
  int didx;

  initial begin
    codes = '{6'b100100, 6'b100101, 6'b100000, 6'b100010, 6'b101010,
              6'b000000, 6'b010000, 6'b010010, 6'b011001, 6'b111111};
    reset    = 1'b1;
    op_valid = 1'b0;
    funct    = '0;
    src_a    = '0;
    src_b    = '0;
    cmp_en   = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_ready", op_ready, 1'b1);
    chk("reset_sel", sel_funct, 6'b000000);
    chk("reset_done", done, 1'b0);
    chk("reset_hilo", {hi_out, lo_out}, 64'h0);
    #1 reset = 1'b0;
    @(negedge clk);

    // ADD 5 + 7
    issue(6'b100000, 32'd5, 32'd7);
    chk("add_done", done, 1'b1);
    chk("add_sel", sel_funct, 6'b100000);
    chk("add_ctrl", alu_ctrl, 3'b010);
    chk("add_illegal", illegal, 1'b0);
    chk("add_hilo", {hi_out, lo_out}, 64'h0);

    // MULTU all-ones squared
    issue(6'b011001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("mul1_sel", sel_funct, 6'b011001);
    wait_mul(low, didx);
    chk("mul1_busy_cycles", low, 33);
    chk("mul1_done_cycle", didx, 32);
    chk("mul1_hi", hi_out, 32'hFFFF_FFFE);
    chk("mul1_lo", lo_out, 32'h0000_0001);
    chk("mul1_done_cleared", done, 1'b0);

    issue(6'b010000, 32'd0, 32'd0);
    chk("mfhi_done", done, 1'b1);
    chk("mfhi_sel", sel_funct, 6'b010000);
    chk("mfhi_hi", hi_out, 32'hFFFF_FFFE);

    // MULTU 2^16 * 2^16
    issue(6'b011001, 32'h0001_0000, 32'h0001_0000);
    wait_mul(low, didx);
    chk("mul2_hi", hi_out, 32'h0000_0001);
    chk("mul2_lo", lo_out, 32'h0000_0000);

    // Reset in the middle of a multiply (cycle N+10)
    issue(6'b011001, 32'd3, 32'd5);
    repeat (9) @(negedge clk);
    chk("midrst_busy", op_ready, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("midrst_ready", op_ready, 1'b1);
    chk("midrst_hilo", {hi_out, lo_out}, 64'h0);
    chk("midrst_done", done, 1'b0);
    chk("midrst_sel", sel_funct, 6'b000000);
    op_valid = 1'b1;
    funct    = 6'b100000;
    src_a    = 32'd1;
    src_b    = 32'd2;
    @(negedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    op_valid = 1'b0;
    chk("postrst_add_done", done, 1'b1);
    chk("postrst_add_sel", sel_funct, 6'b100000);
    chk("postrst_hilo", {hi_out, lo_out}, 64'h0);

    // Back-to-back SLL, SUB, illegal
    op_valid = 1'b1;
    funct    = 6'b000000;
    @(negedge clk);
    chk("b2b0_done", done, 1'b1);
    chk("b2b0_sel", sel_funct, 6'b000000);
    chk("b2b0_ctrl", alu_ctrl, 3'b000);
    chk("b2b0_illegal", illegal, 1'b0);
    funct = 6'b100010;
    @(negedge clk);
    chk("b2b1_done", done, 1'b1);
    chk("b2b1_sel", sel_funct, 6'b100010);
    chk("b2b1_ctrl", alu_ctrl, 3'b110);
    chk("b2b1_illegal", illegal, 1'b0);
    funct = 6'b111111;
    @(negedge clk);
    chk("b2b2_done", done, 1'b1);
    chk("b2b2_sel", sel_funct, 6'b111111);
    chk("b2b2_ctrl", alu_ctrl, 3'b000);
    chk("b2b2_illegal", illegal, 1'b1);
    op_valid = 1'b0;
    @(negedge clk);
    chk("b2b_end_done", done, 1'b0);
    chk("b2b_end_sel_held", sel_funct, 6'b111111);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      int r;
      r        = $urandom_range(0, 15);
      op_valid = ($urandom_range(0, 3) != 0);
      if (r < 10) funct = codes[r];
      else        funct = 6'($urandom);
      if (funct == 6'b011001 && $urandom_range(0, 3) != 0) funct = 6'b100101;
      src_a = $urandom;
      src_b = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
      @(negedge clk);
    end
    op_valid = 1'b0;
    wait_mul(low, didx);
    chk("final_idle", op_ready, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Front-end issue/sequencing unit for the ALU datapath. It accepts an R-type funct code plus operands and decodes the funct into ALU control and result-select codes. It drives the registered select code that the result multiplexer consumes on the falling clock edge. It also owns the Hi/Lo register pair and runs a 32-cycle unsigned shift-add multiply for MULTU, holding off new operations with a valid/ready handshake until the multiply completes.

## Interface
- No parameters; data width fixed at 32.
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high
- op_valid  input  1  operation request
- op_ready  output  1  sequencer can accept; reset 1
- funct  input  6  R-type function code
- src_a  input  32  rs operand (multiplicand for MULTU)
- src_b  input  32  rt operand (multiplier for MULTU)
- sel_funct  output  6  registered result-select code to the result mux; reset 000000
- alu_ctrl  output  3  registered ALU operation code; reset 000
- done  output  1  one-cycle completion pulse; reset 0
- illegal  output  1  qualifies done, funct not recognised; reset 0
- hi_out  output  32  Hi register; reset 0
- lo_out  output  32  Lo register; reset 0

## Operation
- Recognised funct codes:
  - AND 100100, OR 100101, ADD 100000, SUB 100010, SLT 101010, SLL 000000, MFHI 010000, MFLO 010010: single-cycle ops.
  - MULTU 011001: multi-cycle op.
- alu_ctrl encoding: AND 000, OR 001, ADD 010, SUB 110, SLT 111; all other funct values give 000.
- Accept occurs on a rising edge with op_valid && op_ready. funct, src_a and src_b are sampled only at accept.
- Single-cycle op:
  - At the accept edge, sel_funct and alu_ctrl are loaded, and done=1 in the following cycle.
  - Hi/Lo are unchanged.
- Unrecognised funct:
  - Handled as a single-cycle op with done=1 and illegal=1.
  - sel_funct is loaded with the raw funct, so the result mux outputs 0; alu_ctrl=000.
- MULTU:
  - At accept, the multiplicand is latched and the product register is set to {32'b0, src_b}; the counter is cleared.
  - Each MUL cycle: if product[0]=1, product[64:32] = product[63:32] + multiplicand, computed 33 bits wide so the carry is kept. Then the whole product shifts right by 1.
  - After 32 iterations, hi_out=product[63:32] and lo_out=product[31:0] are written together, in the same edge.
  - sel_funct=011001 for the duration of the multiply; alu_ctrl=000.
- State machine:
  - IDLE: op_ready=1. Accepting MULTU moves to MUL; accepting anything else stays in IDLE.
  - MUL: op_ready=0. The counter runs 0..31. At count 31 the state moves to DONE and Hi/Lo are written at that same edge.
  - DONE: op_ready=0, done=1 for one cycle, then IDLE.
- done is deasserted in every cycle that does not follow a completion.
- Hi/Lo hold their values across all non-MULTU ops. An MFHI/MFLO accepted after a MULTU always sees the new product, because op_ready is low until the write is complete.
- Reset asserted at any time, including mid-multiply:
  - State returns to IDLE and the multiply is discarded.
  - Hi/Lo, sel_funct, alu_ctrl, done and illegal all go to 0; op_ready goes to 1.

## Timing
- Single-cycle op: accept at edge N gives done high in cycle N+1. sel_funct and alu_ctrl are valid from edge N and are stable at the following falling edge, where the result mux samples them.
- Back-to-back single-cycle ops: one accepted per cycle; done stays high continuously.
- MULTU: accept at edge N, MUL runs for cycles N+1..N+32, Hi/Lo are written at edge N+32, and done is high in cycle N+33. op_ready is low over cycles N+1..N+33 and returns high from edge N+33.
- op_valid while op_ready=0 is ignored. The requester must hold the request until it is accepted.
- sel_funct is held between accepts; it is not cleared after done.

## Structure
- Shared package `alu_pkg`:
  - funct constants (AND, OR, ADD, SUB, SLT, SLL, MFHI, MFLO, MULTU)
  - alu_ctrl codes
  - state enum {IDLE, MUL, DONE}
- Sub-module `mult32u_seq` is natural. It holds the multiplicand, the 64-bit product register, the 5-bit counter, a start input and a last-iteration output.
- The top level keeps the FSM, the decode logic and the Hi/Lo registers.

## Test plan
- Reset: assert reset asynchronously mid-cycle. All outputs go to their reset values immediately; op_ready=1.
- ADD: accept with src_a=5, src_b=7. One cycle later done=1, sel_funct=100000, alu_ctrl=010, illegal=0, Hi/Lo still 0.
- MULTU: 0xFFFFFFFF × 0xFFFFFFFF.
  - Expect op_ready=0 for 33 cycles, done in cycle N+33, hi_out=0xFFFFFFFE, lo_out=0x00000001.
  - A MFHI then accepted: done next cycle, sel_funct=010000, Hi unchanged.
- MULTU 0x00010000 × 0x00010000: expect hi_out=0x00000001, lo_out=0x00000000.
- Reset mid-multiply: assert reset at cycle N+10 of a MULTU. The FSM returns to IDLE, Hi/Lo=0, no done pulse; a new ADD is accepted on the first edge after reset is released.
- Back-to-back SLL, SUB, funct=111111 on consecutive cycles:
  - done is high for three consecutive cycles.
  - sel_funct sequence 000000 / 100010 / 111111; alu_ctrl 000 / 110 / 000.
  - illegal=1 on the third cycle only.
